// File: rtl/pulse_wave_meter.sv
// Pulse-wave analyser: tracks one full low->high period of the sample stream and
// publishes period, 6-bit duty (sequential restoring divide) and peak amplitude.
module pulse_wave_meter (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic [7:0]  in,
  output logic [15:0] wave_length,
  output logic [5:0]  duty,
  output logic [6:0]  amplitude,
  output logic        meas_valid,
  output logic        timeout,
  output logic        overrun
);

  typedef enum logic [1:0] {WAIT_LOW, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_e;

  state_e      state_q, state_d;
  logic [15:0] p_q, p_d;
  logic [15:0] h_q, h_d;
  logic [7:0]  peak_q, peak_d;
  logic [7:0]  trough_q, trough_d;
  logic        close;
  logic        timeout_d;
  logic        load;
  logic        timeout_q, overrun_q;

  logic        busy_q;
  logic [2:0]  cnt_q;
  logic [15:0] div_p_q;
  logic [15:0] rem_q;
  logic [5:0]  quo_q;
  logic [6:0]  div_amp_q;
  logic [15:0] wl_q;
  logic [5:0]  duty_q;
  logic [6:0]  amp_q;
  logic        mv_q;

  logic        hi;
  logic [7:0]  pk_ex;
  logic [6:0]  pk_amp, tr_amp, amp_now;
  logic [16:0] rem_sh;
  logic [15:0] rem_sub;
  logic        rem_ge;

  assign hi = in[7];

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    h_d       = h_q;
    peak_d    = peak_q;
    trough_d  = trough_q;
    close     = 1'b0;
    timeout_d = 1'b0;
    if (sample_tick) begin
      unique case (state_q)
        WAIT_LOW: if (!hi) state_d = WAIT_RISE;
        WAIT_RISE: begin
          if (hi) begin
            state_d  = MEAS_HIGH;
            p_d      = 16'd1;
            h_d      = 16'd1;
            peak_d   = in;
            trough_d = 8'hFF;
          end
        end
        MEAS_HIGH: begin
          if (p_q == 16'hFFFF) begin
            timeout_d = 1'b1;
            state_d   = WAIT_LOW;
          end else if (hi) begin
            p_d    = p_q + 16'd1;
            h_d    = h_q + 16'd1;
            peak_d = (in > peak_q) ? in : peak_q;
          end else begin
            p_d      = p_q + 16'd1;
            trough_d = (in < trough_q) ? in : trough_q;
            state_d  = MEAS_LOW;
          end
        end
        MEAS_LOW: begin
          if (p_q == 16'hFFFF) begin
            timeout_d = 1'b1;
            state_d   = WAIT_LOW;
          end else if (!hi) begin
            p_d      = p_q + 16'd1;
            trough_d = (in < trough_q) ? in : trough_q;
          end else begin
            // Closing tick also opens the next period, whether or not the divider takes it.
            close    = 1'b1;
            p_d      = 16'd1;
            h_d      = 16'd1;
            peak_d   = in;
            trough_d = 8'hFF;
            state_d  = MEAS_HIGH;
          end
        end
        default: state_d = WAIT_LOW;
      endcase
    end
  end

  assign load = close && !busy_q;

  // Peak is always >= 128 here; 255 is the only value that needs clamping.
  assign pk_ex   = peak_q - 8'd127;
  assign pk_amp  = pk_ex[7] ? 7'd127 : pk_ex[6:0];
  assign tr_amp  = 7'd127 - trough_q[6:0];
  assign amp_now = (pk_amp > tr_amp) ? pk_amp : tr_amp;

  assign rem_sh  = {rem_q, 1'b0};
  assign rem_ge  = rem_sh >= {1'b0, div_p_q};
  assign rem_sub = rem_sh[15:0] - div_p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOW;
      p_q       <= '0;
      h_q       <= '0;
      peak_q    <= '0;
      trough_q  <= '1;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      h_q       <= h_d;
      peak_q    <= peak_d;
      trough_q  <= trough_d;
      timeout_q <= timeout_d;
      overrun_q <= close && busy_q;
    end
  end

  // Divider: load at the closing edge, six iterations, publish on the seventh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      div_p_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_amp_q <= '0;
      wl_q      <= '0;
      duty_q    <= '0;
      amp_q     <= '0;
      mv_q      <= 1'b0;
    end else begin
      mv_q <= 1'b0;
      if (load) begin
        busy_q    <= 1'b1;
        cnt_q     <= '0;
        div_p_q   <= p_q;
        rem_q     <= h_q;
        quo_q     <= '0;
        div_amp_q <= amp_now;
      end else if (busy_q) begin
        if (cnt_q == 3'd6) begin
          busy_q <= 1'b0;
          wl_q   <= div_p_q;
          duty_q <= quo_q;
          amp_q  <= div_amp_q;
          mv_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 3'd1;
          rem_q <= rem_ge ? rem_sub : rem_sh[15:0];
          quo_q <= {quo_q[4:0], rem_ge};
        end
      end
    end
  end

  assign wave_length = wl_q;
  assign duty        = duty_q;
  assign amplitude   = amp_q;
  assign meas_valid  = mv_q;
  assign timeout     = timeout_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pulse_wave_meter.sv
// Bench for pulse_wave_meter: per-cycle comparison against a period-level
// reference model, plus table-driven waveforms with fixed expected results.
module tb_pulse_wave_meter;

  logic        clk;
  logic        rst;
  logic        sample_tick;
  logic [7:0]  din;
  logic [15:0] wave_length;
  logic [5:0]  duty;
  logic [6:0]  amplitude;
  logic        meas_valid;
  logic        timeout;
  logic        overrun;

  pulse_wave_meter dut (
    .clk         (clk),
    .rst         (rst),
    .sample_tick (sample_tick),
    .in          (din),
    .wave_length (wave_length),
    .duty        (duty),
    .amplitude   (amplitude),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a period is the list of samples from a rising sample up to
  // (not including) the next rising sample that follows at least one low sample.
  int     mq[$];
  bit     m_armed, m_inper, m_lowseen;
  longint m_edge = 0;
  longint m_last_acc = -100;
  bit     m_pend;
  longint m_pend_edge;
  int     m_pwl, m_pduty, m_pamp;
  int     e_wl, e_duty, e_amp;
  bit     e_mv, e_to, e_ov;

  // Scenario monitors
  bit tab_on = 0, mon_on = 0;
  int tab_cnt, cur_wl, cur_dt, cur_am;
  int mon_mv, mon_to, mon_ov;

  typedef struct {
    int hv, hn, lv, ln, gap, reps;
    int wl, dt, am, cnt;
  } vec_t;
  vec_t tab[5];

  task automatic cmp(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic void model_close();
    int p, h, pk, tr, a1, a2;
    p = mq.size(); h = 0; pk = 0; tr = 255;
    foreach (mq[i]) begin
      if (mq[i] >= 128) h++;
      if (mq[i] > pk) pk = mq[i];
      if (mq[i] < tr) tr = mq[i];
    end
    a1 = pk - 127; if (a1 > 127) a1 = 127;
    a2 = 127 - tr;
    if (m_edge - m_last_acc >= 8) begin
      m_last_acc  = m_edge;
      m_pend      = 1;
      m_pend_edge = m_edge + 7;
      m_pwl       = p;
      m_pduty     = (64 * h) / p;
      m_pamp      = (a1 > a2) ? a1 : a2;
    end else begin
      e_ov = 1;
    end
  endfunction

  function automatic void model_edge(input bit t, input int s, input bit r);
    bit hi;
    m_edge++;
    e_mv = 0; e_to = 0; e_ov = 0;
    if (r) begin
      mq.delete();
      m_armed = 0; m_inper = 0; m_lowseen = 0; m_pend = 0;
      m_last_acc = -100;
      e_wl = 0; e_duty = 0; e_amp = 0;
      return;
    end
    if (m_pend && m_edge == m_pend_edge) begin
      e_wl = m_pwl; e_duty = m_pduty; e_amp = m_pamp; e_mv = 1; m_pend = 0;
    end
    if (t) begin
      hi = (s >= 128);
      if (m_inper && mq.size() == 65535) begin
        e_to = 1; m_inper = 0; m_armed = 0; mq.delete();
      end else if (m_inper) begin
        if (hi && m_lowseen) begin
          model_close();
          mq.delete(); mq.push_back(s); m_lowseen = 0;
        end else begin
          mq.push_back(s);
          if (!hi) m_lowseen = 1;
        end
      end else if (!m_armed) begin
        if (!hi) m_armed = 1;
      end else if (hi) begin
        m_inper = 1; mq.delete(); mq.push_back(s); m_lowseen = 0;
      end
    end
  endfunction

  task automatic check_outputs();
    cmp("wave_length", int'(wave_length), e_wl);
    cmp("duty",        int'(duty),        e_duty);
    cmp("amplitude",   int'(amplitude),   e_amp);
    cmp("meas_valid",  int'(meas_valid),  int'(e_mv));
    cmp("timeout",     int'(timeout),     int'(e_to));
    cmp("overrun",     int'(overrun),     int'(e_ov));
    if (tab_on && meas_valid) begin
      tab_cnt++;
      cmp("tab_wave_length", int'(wave_length), cur_wl);
      cmp("tab_duty",        int'(duty),        cur_dt);
      cmp("tab_amplitude",   int'(amplitude),   cur_am);
    end
    if (mon_on) begin
      if (meas_valid) mon_mv++;
      if (timeout)    mon_to++;
      if (overrun)    mon_ov++;
    end
  endtask

  task automatic cyc(input bit t, input int s, input bit r);
    @(negedge clk);
    sample_tick = t; din = 8'(s); rst = r;
    @(posedge clk);
    model_edge(t, s, r);
    #1 check_outputs();
  endtask

  task automatic tick_gap(input int s, input int gap);
    cyc(1, s, 0);
    for (int i = 1; i < gap; i++) cyc(0, s, 0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 1);
    cyc(0, 0, 1);
  endtask

  task automatic mon_start();
    mon_on = 1; mon_mv = 0; mon_to = 0; mon_ov = 0;
  endtask

  initial begin
    int run_left;
    bit run_hi;
    int s;

    rst = 1'b1; sample_tick = 1'b0; din = 8'd0;

    tab[0] = '{hv:200, hn:2, lv:50,  ln:5,  gap:4,   reps:3, wl:7,  dt:18, am:77,  cnt:2};
    tab[1] = '{hv:177, hn:4, lv:77,  ln:12, gap:100, reps:3, wl:16, dt:16, am:50,  cnt:2};
    tab[2] = '{hv:255, hn:3, lv:0,   ln:4,  gap:3,   reps:4, wl:7,  dt:27, am:127, cnt:3};
    tab[3] = '{hv:140, hn:5, lv:100, ln:3,  gap:2,   reps:4, wl:8,  dt:40, am:27,  cnt:3};
    tab[4] = '{hv:128, hn:1, lv:127, ln:1,  gap:10,  reps:5, wl:2,  dt:32, am:1,   cnt:4};

    do_reset();
    cmp("rst_wave_length", int'(wave_length), 0);
    cmp("rst_duty",        int'(duty),        0);
    cmp("rst_amplitude",   int'(amplitude),   0);
    cmp("rst_meas_valid",  int'(meas_valid),  0);

    // Table-driven waveforms; each starts mid-high so the first partial period is skipped.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      cur_wl = tab[v].wl; cur_dt = tab[v].dt; cur_am = tab[v].am;
      tab_cnt = 0; tab_on = 1;
      for (int r = 0; r < tab[v].reps; r++) begin
        for (int k = 0; k < tab[v].hn; k++) tick_gap(tab[v].hv, tab[v].gap);
        for (int k = 0; k < tab[v].ln; k++) tick_gap(tab[v].lv, tab[v].gap);
      end
      tick_gap(tab[v].hv, tab[v].gap);
      repeat (12) cyc(0, tab[v].hv, 0);
      tab_on = 0;
      cmp("tab_result_count", tab_cnt, tab[v].cnt);
    end

    // Loss of signal after lock, then relock.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      repeat (4)  cyc(1, 177, 0);
      repeat (12) cyc(1, 77, 0);
    end
    repeat (11) cyc(1, 200, 0);
    mon_start();
    repeat (65600) cyc(1, 200, 0);
    mon_on = 0;
    cmp("to_pulses",       mon_to, 1);
    cmp("to_meas_valid",   mon_mv, 0);
    cmp("to_keep_wl",      int'(wave_length), 16);
    cmp("to_keep_duty",    int'(duty),        16);
    cmp("to_keep_amp",     int'(amplitude),   50);
    mon_start();
    repeat (12) cyc(1, 77, 0);
    repeat (4)  cyc(1, 177, 0);
    repeat (12) cyc(1, 77, 0);
    cyc(1, 177, 0);
    repeat (10) cyc(0, 177, 0);
    mon_on = 0;
    cmp("relock_meas_valid", mon_mv, 1);
    cmp("relock_wl",         int'(wave_length), 16);

    // P=2 with a tick every clock: closes inside the busy window overrun.
    do_reset();
    cur_wl = 2; cur_dt = 32; cur_am = 77; tab_cnt = 0; tab_on = 1;
    mon_start();
    for (int i = 0; i < 40; i++) cyc(1, (i % 2 == 0) ? 50 : 200, 0);
    repeat (10) cyc(0, 50, 0);
    mon_on = 0; tab_on = 0;
    cmp("ovr_seen",   int'(mon_ov > 0), 1);
    cmp("ovr_accept", int'(mon_mv > 0), 1);

    // Reset three clocks after a closing tick aborts the divide.
    do_reset();
    cyc(1, 50, 0); cyc(1, 200, 0); cyc(1, 200, 0);
    cyc(1, 50, 0); cyc(1, 50, 0);
    cyc(1, 200, 0);
    cyc(0, 200, 0); cyc(0, 200, 0);
    mon_start();
    cyc(0, 200, 1);
    repeat (15) cyc(0, 200, 0);
    mon_on = 0;
    cmp("abort_meas_valid", mon_mv, 0);
    cmp("abort_wl",         int'(wave_length), 0);
    cmp("abort_duty",       int'(duty),        0);
    cmp("abort_amp",        int'(amplitude),   0);
    cur_wl = 3; cur_dt = 21; cur_am = 77; tab_cnt = 0; tab_on = 1;
    cyc(1, 200, 0); cyc(1, 200, 0);
    cyc(1, 50, 0); cyc(1, 200, 0); cyc(1, 50, 0); cyc(1, 50, 0);
    cyc(1, 200, 0);
    repeat (10) cyc(0, 200, 0);
    tab_on = 0;
    cmp("abort_fsm_relock", tab_cnt, 1);

    // Randomized runs of high/low samples with sparse ticks and occasional reset.
    do_reset();
    run_left = 0; run_hi = 0;
    for (int i = 0; i < 3000; i++) begin
      bit t, r;
      if (run_left == 0) begin
        run_hi = $urandom_range(0, 1) == 1;
        run_left = $urandom_range(1, 5);
      end
      case ($urandom_range(0, 7))
        0:       s = run_hi ? 128 : 127;
        1:       s = run_hi ? 255 : 0;
        default: s = run_hi ? $urandom_range(128, 255) : $urandom_range(0, 127);
      endcase
      t = $urandom_range(0, 2) != 0;
      r = $urandom_range(0, 799) == 0;
      if (t) run_left--;
      cyc(t, s, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pulse_wave_meter.md
# pulse_wave_meter

Measures an incoming 8-bit, mid-scale-centred (127) pulse-wave sample stream and recovers its period in samples, 6-bit duty and peak amplitude. It is the analysis counterpart to the synth's pulse-wave generator, driven on the same 20 kHz `sample_tick`. It sits on the sample bus for self-test and for tuner/display features. Results are produced once per complete period through a sequential duty divider.

## Interface
- No parameters; all widths are fixed.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `sample_tick` input 1: one-`clk` strobe; `in` is sampled only on cycles where this is high.
- `in` input 8: sample; 127 = mid-scale.
- `wave_length` output 16: last measured period in samples.
- `duty` output 6: floor(64·H/P), where H = high samples and P = period.
- `amplitude` output 7: max(peak−127, 127−trough) over the period, clamped to 127.
- `meas_valid` output 1: one-cycle pulse when a new result is loaded.
- `timeout` output 1: one-cycle pulse on loss of signal.
- `overrun` output 1: one-cycle pulse when a period closes while the divider is busy.

## Operation
- Sample class: high if `in` ≥ 128, else low. Equal to 127 counts as low.
- State machine (advances only on `sample_tick`):
  - `WAIT_LOW`: wait for a low sample, then go to `WAIT_RISE`.
  - `WAIT_RISE`: wait for a high sample. On it, go to `MEAS_HIGH` with P=1, H=1, peak=`in`, trough=255.
  - `MEAS_HIGH`:
    - high sample: P++, H++, peak = max(peak, `in`).
    - low sample: P++, trough = min(trough, `in`), go to `MEAS_LOW`.
  - `MEAS_LOW`:
    - low sample: P++, trough = min(trough, `in`).
    - high sample (closing tick): latch P, H, peak and trough into the divider. Restart P=1, H=1, peak=`in`, trough=255. Go to `MEAS_HIGH`.
- Timeout: a tick in `MEAS_HIGH`/`MEAS_LOW` while P = 0xFFFF pulses `timeout`, goes to `WAIT_LOW`, and discards the partial period. Published outputs are kept.
- Divider: restoring division, 6 iterations.
  - Start: remainder = H (17-bit), quotient = 0.
  - Each iteration: remainder <<= 1; if remainder ≥ P, subtract P and shift in 1, else shift in 0.
  - H < P always, so the quotient fits in 6 bits.
- Amplitude: peak−127 clamped to 127 (`in`=255 gives 127); 127−trough.
- Overrun: a closing tick while the divider is busy is dropped.
  - `overrun` pulses.
  - Counters still restart so the next period is measured normally.
- The divider is idle on reset.

## Timing
- Reset values: `wave_length`=0, `duty`=0, `amplitude`=0, `meas_valid`=0, `timeout`=0, `overrun`=0; state `WAIT_LOW`; divider idle.
- Closing tick sampled at edge E0. Divider loads at E0, iterates at E1..E6. Outputs are registered and `meas_valid`=1 during the cycle after E7, for exactly one cycle.
- Divider is busy from E0 through E7. A closing tick at E1..E7 causes an overrun. A closing tick at E8 or later is accepted.
- Published outputs change only together with `meas_valid`.
- `rst` asserted mid-divide: aborts the division, no `meas_valid`, all outputs return to reset values on the next edge.
- `sample_tick` low: no state or counter changes. The divider continues independently of ticks.
- `timeout` and `overrun` are registered and pulse the cycle after the triggering tick edge.

## Test plan
- 4 samples of 177, then 12 of 77, repeated; ticks every 100 clk:
  - First `meas_valid` comes after the second rising edge: `wave_length`=16, `duty`=16, `amplitude`=50.
  - Each later period repeats these values.
- 3 samples of 255 and 4 of 0, repeated: `wave_length`=7, `duty`=27, `amplitude`=127 (clamped).
- Stream starting mid-high (200, 200, then 50 ×5, then 200 …): the first partial period is ignored; the first result is for a full period.
- Constant 200 for 70 000 ticks after lock: exactly one `timeout` pulse, no further `meas_valid`, outputs retain the last result. A later valid wave relocks.
- `sample_tick` held high every clk with alternating 200/50 (P=2): `overrun` pulses on closes that fall inside the busy window. Accepted results show `wave_length`=2, `duty`=32.
- `rst` pulsed 3 clk after a closing tick: no `meas_valid`, all outputs 0, FSM in `WAIT_LOW`.
